// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA-to-Wishbone responder.
package dma_pkg;

    // Responder FSM encoding; the top maps these onto plain localparams.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } dma_state_e;

    // Read data returned with any failed transfer.
    localparam logic [31:0] DMA_ERR_DATA = 32'hDEAD_BEEF;

    // Full-word byte lanes; only single-word transfers exist.
    localparam logic [3:0]  WB_SEL_ALL   = 4'hF;

    // Word-aligned and inside the inclusive [lo, hi] byte window.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/dma_wb_timer.sv
// Bus-cycle watchdog: loaded with the timeout on BUS entry, counts down
// once per BUS cycle and flags the last permitted cycle.
module dma_wb_timer
    import dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    // A zero timeout would give a zero-width counter; keep one bit instead.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TW-1:0] count;

    // Down-counter: N in the first BUS cycle, 1 in the N-th.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(TIMEOUT_CYCLES);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Terminal count; never fires when the timeout is disabled.
    assign expired = (TIMEOUT_CYCLES != 0) && (count == TW'(1));

endmodule

// File: rtl/dma_wb_responder.sv
// Memory-side responder: turns single-word DMA requests into classic
// Wishbone cycles, with address-window/alignment checks and a bus timeout.
//
// state | meaning
// IDLE  | waiting for dma_req; latches and checks the request
// BUS   | Wishbone cycle in progress (cyc/stb high)
// RESP  | one-cycle dma_ack with outcome; counters update
module dma_wb_responder
    import dma_pkg::*;
#(
    parameter logic [31:0] ADDR_LO        = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI        = 32'hFFFF_FFFC,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        err_clr,
    output logic [31:0] xfer_count,
    output logic [15:0] err_count,
    output logic        err_sticky
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUS  = ST_BUS;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       we_q;
    logic       resp_err;
    logic       in_bus;
    logic       accept;
    logic       req_legal;
    logic       tmr_load;
    logic       tmr_expired;

    assign in_bus    = (state == BUS);
    assign accept    = (state == IDLE) && dma_req;
    assign req_legal = addr_legal(dma_addr, ADDR_LO, ADDR_HI);
    assign tmr_load  = accept && req_legal;

    dma_wb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .en      (in_bus),
        .expired (tmr_expired)
    );

    // Next-state: any bus response or the timer ends BUS; RESP lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dma_req) begin
                    state_nxt = req_legal ? BUS : RESP;
                end
            end
            BUS: begin
                if (wbm_err_i || wbm_ack_i || tmr_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any transfer in flight without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request once at acceptance; the requester may change it afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            we_q      <= 1'b0;
        end else if (accept) begin
            wbm_adr_o <= dma_addr;
            wbm_dat_o <= dma_wdata;
            we_q      <= dma_we;
        end
    end

    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus && we_q;
    assign wbm_sel_o = in_bus ? WB_SEL_ALL : 4'h0;

    // Outcome and read data; bus err beats ack, any bus response beats the timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err  <= 1'b0;
            dma_rdata <= '0;
        end else if (accept && !req_legal) begin
            resp_err  <= 1'b1;
            dma_rdata <= DMA_ERR_DATA;
        end else if (in_bus) begin
            if (wbm_err_i) begin
                resp_err  <= 1'b1;
                dma_rdata <= DMA_ERR_DATA;
            end else if (wbm_ack_i) begin
                resp_err <= 1'b0;
                if (!we_q) begin
                    dma_rdata <= wbm_dat_i;
                end
            end else if (tmr_expired) begin
                resp_err  <= 1'b1;
                dma_rdata <= DMA_ERR_DATA;
            end
        end
    end

    assign dma_ack = (state == RESP);
    assign dma_err = dma_ack && resp_err;

    // Statistics; a failure in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (dma_ack && !resp_err) begin
                xfer_count <= xfer_count + 32'd1;
            end
            if (dma_ack && resp_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (dma_ack && resp_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dma_wb_responder.md
# dma_wb_responder

Memory-side responder for the accelerator DMA port. It accepts single-word read/write requests on the `dma_req`/`dma_ack` interface, issues them as classic Wishbone master cycles to system memory, and returns read data and completion. It also enforces an address window, alignment and a bus timeout. It sits between the matrix accelerator's DMA initiator port and the system Wishbone interconnect.

## Interface
- `ADDR_LO`, default 32'h0000_0000: lowest legal byte address, inclusive.
- `ADDR_HI`, default 32'hFFFF_FFFC: highest legal byte address, inclusive.
- `TIMEOUT_CYCLES`, default 255: maximum cycles in BUS before abort. 0 disables the timeout.
- `clk` in 1: clock `clk`.
- `reset` in 1: reset `reset`, synchronous, active-high.
- `dma_req` in 1: requester has a valid transfer; level, held until `dma_ack`.
- `dma_we` in 1: 1 = write, 0 = read.
- `dma_addr` in 32: byte address, word-aligned.
- `dma_wdata` in 32: write data.
- `dma_ack` out 1: one-cycle completion pulse.
- `dma_rdata` out 32: read data; valid in the `dma_ack` cycle.
- `dma_err` out 1: qualifies `dma_ack`; 1 = transfer failed.
- `wbm_adr_o` out 32: Wishbone address.
- `wbm_dat_o` out 32: Wishbone write data.
- `wbm_dat_i` in 32: Wishbone read data.
- `wbm_we_o` out 1: Wishbone write enable.
- `wbm_sel_o` out 4: byte selects; always 4'hF during a cycle.
- `wbm_cyc_o` out 1: Wishbone cycle.
- `wbm_stb_o` out 1: Wishbone strobe.
- `wbm_ack_i` in 1: Wishbone acknowledge.
- `wbm_err_i` in 1: Wishbone error.
- `err_clr` in 1: clears `err_sticky`.
- `xfer_count` out 32: count of successful transfers; wraps.
- `err_count` out 16: count of failed transfers; saturates at 16'hFFFF.
- `err_sticky` out 1: set by any failed transfer.

## Operation
- States:
  - IDLE
  - BUS
  - RESP
- IDLE, `dma_req`=1 at an edge:
  - Latch `dma_addr`, `dma_we` and `dma_wdata`.
  - If `addr[1:0]`≠0, or addr<`ADDR_LO`, or addr>`ADDR_HI`: go to RESP with error. No bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - `wbm_cyc_o` = `wbm_stb_o` = 1, with `wbm_adr_o`, `wbm_we_o` and `wbm_dat_o` driven from the latched values.
  - A timer counts cycles spent in BUS.
- BUS exits:
  - `wbm_ack_i`=1: capture `wbm_dat_i` into `dma_rdata` (reads only; writes leave `dma_rdata` unchanged), then go to RESP OK.
  - `wbm_err_i`=1: go to RESP error.
  - Timer reaches `TIMEOUT_CYCLES` with neither ack nor err: go to RESP error.
- RESP:
  - `dma_ack`=1 for exactly one cycle; `dma_err` set per the outcome.
  - On error, `dma_rdata` = 32'hDEADBEEF.
  - Update the counters, then return to IDLE.
- Counters and sticky flag:
  - OK outcome: `xfer_count` increments.
  - Error outcome: `err_count` increments (saturating) and `err_sticky` sets.
  - `err_clr` clears `err_sticky`. If an error and `err_clr` land in the same cycle, the error wins.
- `dma_req` dropping while in BUS does not abort the transfer. The cycle completes and `dma_ack` still pulses.
- `wbm_cyc_o`/`wbm_stb_o` are low in IDLE and RESP.

## Timing
- Reset values:
  - state IDLE
  - `dma_ack`, `dma_err`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0
  - `wbm_sel_o` = 0
  - `wbm_adr_o`, `wbm_dat_o`, `dma_rdata` = 0
  - `xfer_count`, `err_count`, `err_sticky` = 0
- Reset mid-BUS: `cyc`/`stb` are low after the reset edge. No `dma_ack` is produced for the aborted transfer.
- Request accepted at edge k: `cyc`/`stb` are high from cycle k+1.
- `wbm_ack_i` sampled at edge m: `cyc`/`stb` are low and `dma_ack`=1 in cycle m+1.
- Zero-wait slave: 3 cycles per transfer (IDLE, BUS, RESP). Back-to-back requests: IDLE re-samples in the cycle after RESP, so the requester's post-ack address update is seen.
- Window/alignment error: `dma_ack`+`dma_err` appear in cycle k+1, with no `cyc`.
- Timeout: with `TIMEOUT_CYCLES`=N, abort occurs after N BUS cycles. `cyc` stays high for exactly N cycles, and `dma_ack` comes in the following cycle.
- `wbm_ack_i` and `wbm_err_i` in the same cycle: err wins.
- Ack or err in the same cycle as timer expiry: the bus response wins.

## Structure
- Package `dma_pkg`, containing:
  - state enum (IDLE/BUS/RESP)
  - `DMA_ERR_DATA` = 32'hDEADBEEF
  - `WB_SEL_ALL` = 4'hF
- Sub-module `dma_wb_timer`:
  - load/clear on BUS entry, enable in BUS, `expired` output.
  - Parameter width = `$clog2(TIMEOUT_CYCLES+1)`.
  - `expired` is tied 0 when `TIMEOUT_CYCLES`=0.

## Test plan
- Read at 0x100, slave acks in the first BUS cycle with 0x12345678 → `dma_ack` 2 cycles after acceptance, `dma_rdata`=0x12345678, `dma_err`=0, `xfer_count`=1.
- Write at 0x104, data 0xA5A5A5A5, slave with 3 wait states → `wbm_we_o`=1, `wbm_dat_o`=0xA5A5A5A5, `wbm_sel_o`=F, `cyc` high 4 cycles, one `dma_ack`.
- Address 0x102, then address above `ADDR_HI` → each gives `dma_ack`+`dma_err` with no `cyc`, `dma_rdata`=0xDEADBEEF, `err_count`=2, `err_sticky`=1; `err_clr` then clears the sticky flag.
- `TIMEOUT_CYCLES`=4, silent slave → `cyc` high exactly 4 cycles, then error `dma_ack`. Ack and err asserted together → error response.
- 64 back-to-back reads from an incrementing requester → 192 cycles total, each address seen once, `xfer_count`=64.
- Reset asserted in the 2nd BUS cycle → `cyc` low next cycle, no `dma_ack`, all counters 0, state IDLE.
